// File: rtl/priority_arbiter_4_to_2_if.sv
// priority_arbiter_4_to_2_if: request/grant bundle between masters and the arbiter
interface priority_arbiter_4_to_2_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;
    modport master (output req, input grant, grant_id, grant_valid, timeout);
    modport slave  (input req, output grant, grant_id, grant_valid, timeout);
endinterface

// File: rtl/priority_arbiter_4_to_2.sv
// priority_arbiter_4_to_2: fixed-priority 4-way arbiter with hold limit and one-shot mask after a forced release
module priority_arbiter_4_to_2 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    priority_arbiter_4_to_2_if.slave   io_bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
    state_t     r_state, w_state_nx;
    logic [3:0] r_grant, w_grant_nx, r_mask, w_mask_nx, w_eff_m, w_eff;
    logic [1:0] r_grant_id, w_grant_id_nx, w_top;
    logic       r_grant_valid, w_grant_valid_nx, r_timeout, w_timeout_nx;
    logic [7:0] r_hold_cnt, w_hold_cnt_nx;
    // a requester that just timed out is skipped once, unless it is the only one asking
    assign w_eff_m = io_bus.req & ~r_mask;
    assign w_eff   = |w_eff_m ? w_eff_m : io_bus.req;
    assign w_top   = w_eff[3] ? 2'd3 : w_eff[2] ? 2'd2 : w_eff[1] ? 2'd1 : 2'd0;
    always_comb begin
        w_state_nx       = r_state;
        w_grant_nx       = r_grant;
        w_grant_id_nx    = r_grant_id;
        w_grant_valid_nx = r_grant_valid;
        w_timeout_nx     = 1'b0;
        w_hold_cnt_nx    = r_hold_cnt;
        w_mask_nx        = r_mask;
        case (r_state)
            IDLE: if (|w_eff) begin
                w_state_nx       = BUSY;
                w_grant_nx       = 4'(1) << w_top;
                w_grant_id_nx    = w_top;
                w_grant_valid_nx = 1'b1;
                w_hold_cnt_nx    = 8'd0;
                w_mask_nx        = 4'd0;
            end
            BUSY: if (!io_bus.req[r_grant_id]) begin
                w_state_nx       = IDLE;
                w_grant_nx       = 4'd0;
                w_grant_valid_nx = 1'b0;
            end else if (r_hold_cnt == LAST) begin
                w_state_nx       = RELEASE;
                w_grant_nx       = 4'd0;
                w_grant_valid_nx = 1'b0;
                w_timeout_nx     = 1'b1;
                w_mask_nx        = r_grant;
            end else begin
                w_hold_cnt_nx    = r_hold_cnt + 8'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= 4'd0;
            r_grant_id    <= 2'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_mask        <= 4'd0;
        end else begin
            r_state       <= w_state_nx;
            r_grant       <= w_grant_nx;
            r_grant_id    <= w_grant_id_nx;
            r_grant_valid <= w_grant_valid_nx;
            r_timeout     <= w_timeout_nx;
            r_hold_cnt    <= w_hold_cnt_nx;
            r_mask        <= w_mask_nx;
        end
    end
    assign io_bus.grant       = r_grant;
    assign io_bus.grant_id    = r_grant_id;
    assign io_bus.grant_valid = r_grant_valid;
    assign io_bus.timeout     = r_timeout;
endmodule

// File: tb/tb_priority_arbiter_4_to_2.sv
// tb_priority_arbiter_4_to_2: directed + random stimulus, queue scoreboard against a behavioural model
module tb_priority_arbiter_4_to_2;
    localparam int MAX_HOLD = 8;
    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       t;
    } exp_t;
    typedef struct {
        logic [3:0] r;
        int         n;
        logic       rs;
    } step_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_owner = -1;
    int   m_held = 0;
    int   m_mask = -1;
    int   m_id = 0;
    bit   m_to = 1'b0;
    bit   done = 1'b0;
    priority_arbiter_4_to_2_if bus();
    priority_arbiter_4_to_2 #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    // model: owner keeps grant while requesting, for at most MAX_HOLD cycles; a forced
    // release costs one dead cycle and makes that requester yield once to any other requester
    task automatic model_step(input logic [3:0] r, input logic rs);
        int pick;
        if (rs) begin
            m_owner = -1; m_held = 0; m_mask = -1; m_id = 0; m_to = 1'b0;
        end else if (m_to) begin
            m_to = 1'b0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) m_owner = -1;
            else if (m_held == MAX_HOLD) begin
                m_mask = m_owner; m_owner = -1; m_to = 1'b1;
            end else m_held++;
        end else begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (pick < 0 && r[i] && i != m_mask) pick = i;
            for (int i = 3; i >= 0; i--) if (pick < 0 && r[i]) pick = i;
            if (pick >= 0) begin
                m_owner = pick; m_held = 1; m_mask = -1; m_id = pick;
            end
        end
    endtask
    task automatic cycle(input logic [3:0] r, input logic rs);
        exp_t e;
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        rst = rs;
        bus.req = r;
        model_step(r, rs);
        e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.id = 2'(m_id);
        e.v  = (m_owner >= 0);
        e.t  = m_to;
        q.push_back(e);
        if (rs && !was_rst) begin
            #1;
            chk("async_rst_grant", {4'd0, bus.grant}, 8'd0);
            chk("async_rst_timeout", {7'd0, bus.timeout}, 8'd0);
        end
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", {4'd0, bus.grant}, {4'd0, e.g});
                chk("grant_id", {6'd0, bus.grant_id}, {6'd0, e.id});
                chk("grant_valid", {7'd0, bus.grant_valid}, {7'd0, e.v});
                chk("timeout", {7'd0, bus.timeout}, {7'd0, e.t});
                chk("onehot", {7'd0, $onehot0(bus.grant)}, 8'd1);
                chk("to_vs_valid", {7'd0, bus.timeout & bus.grant_valid}, 8'd0);
            end
        end
    end
    initial begin : stim
        step_t tbl[$];
        logic [3:0] r;
        bus.req = 4'b1111;
        tbl = '{
            '{4'b1111, 3, 1'b1}, '{4'b0001, 2, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b0110, 3, 1'b0}, '{4'b1110, 3, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b1011, 4, 1'b0}, '{4'b0011, 3, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b1001, 14, 1'b0}, '{4'b1000, 4, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b0100, 14, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b0010, 8, 1'b0}, '{4'b0000, 2, 1'b0},
            '{4'b1001, 12, 1'b0}, '{4'b1001, 2, 1'b1}, '{4'b0000, 1, 1'b0},
            '{4'b1001, 3, 1'b0}, '{4'b0000, 2, 1'b0}
        };
        foreach (tbl[k]) for (int j = 0; j < tbl[k].n; j++) cycle(tbl[k].r, tbl[k].rs);
        r = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, ($urandom_range(0, 399) == 0));
        end
        @(posedge clk);
        #3;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
